// File: rtl/snake_pkg.sv
// Shared definitions for the snake game blocks: FSM state encoding,
// default screen geometry and BCD digit width.
package snake_pkg;

  typedef enum logic [1:0] {
    PLAY = 2'd0,
    EAT  = 2'd1,
    DEAD = 2'd2
  } state_e;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;
  localparam int BORDER_DEF   = 10;
  localparam int BCD_W        = 4;

endpackage

// File: rtl/bcd_add_sat.sv
// Combinational 4-digit BCD adder with a single-digit addend.
// Any carry out of the top digit means the sum passed 9999, so the result pins there.
module bcd_add_sat
  import snake_pkg::*;
(
  input  logic [4*BCD_W-1:0] bcd_i,
  input  logic [BCD_W-1:0]   addend_i,
  output logic [4*BCD_W-1:0] sum_o
);

  logic [4*BCD_W-1:0] res;
  logic [BCD_W:0]     carry;
  logic [BCD_W:0]     digit;

  // Ripple through the digits; a valid digit plus addend plus carry never exceeds 19.
  always_comb begin
    res   = '0;
    carry = {1'b0, addend_i};
    digit = '0;
    for (int i = 0; i < 4; i++) begin
      digit = {1'b0, bcd_i[i*BCD_W +: BCD_W]} + carry;
      if (digit > 5'd9) begin
        res[i*BCD_W +: BCD_W] = 4'(digit - 5'd10);
        carry = 5'd1;
      end else begin
        res[i*BCD_W +: BCD_W] = digit[BCD_W-1:0];
        carry = 5'd0;
      end
    end
    sum_o = (carry != 5'd0) ? 16'h9999 : res;
  end

endmodule

// File: rtl/apple_eat_detect.sv
// Per-frame collision judge: collects apple/self/wall hits during the scan and,
// at each vsync falling edge, decides between eating, dying or carrying on.
module apple_eat_detect
  import snake_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int BORDER   = BORDER_DEF,
  parameter int POINTS   = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        vert_sync,
  input  logic [9:0]  pixel_row,
  input  logic [9:0]  pixel_column,
  input  logic        is_apple,
  input  logic        is_snake_head,
  input  logic        is_snake_body,
  input  logic        restart,
  output logic        got_apple,
  output logic        grow,
  output logic        game_over,
  output logic [15:0] score_bcd
);

  localparam logic [9:0] COL_LO = 10'(BORDER);
  localparam logic [9:0] COL_HI = 10'(H_ACTIVE - BORDER);
  localparam logic [9:0] ROW_LO = 10'(BORDER);
  localparam logic [9:0] ROW_HI = 10'(V_ACTIVE - BORDER);
  localparam logic [3:0] PTS    = 4'(POINTS);

  state_e      state_q;
  logic        vsync_q;
  logic        eat_q, self_q, wall_q;
  logic        got_apple_q, grow_q, game_over_q;
  logic [15:0] score_q, score_d;
  logic        frame_end, in_band, death;

  assign frame_end = vsync_q & ~vert_sync;
  assign in_band   = (pixel_column < COL_LO) || (pixel_column >= COL_HI) ||
                     (pixel_row < ROW_LO) || (pixel_row >= ROW_HI);
  assign death     = self_q | wall_q;

  bcd_add_sat u_add (
    .bcd_i    (score_q),
    .addend_i (PTS),
    .sum_o    (score_d)
  );

  // Hits seen while dead are discarded so a mid-frame restart starts clean.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= PLAY;
      vsync_q     <= 1'b0;
      eat_q       <= 1'b0;
      self_q      <= 1'b0;
      wall_q      <= 1'b0;
      got_apple_q <= 1'b0;
      grow_q      <= 1'b0;
      game_over_q <= 1'b0;
      score_q     <= 16'h0000;
    end else begin
      vsync_q <= vert_sync;
      grow_q  <= 1'b0;
      if (frame_end || state_q == DEAD) begin
        eat_q  <= 1'b0;
        self_q <= 1'b0;
        wall_q <= 1'b0;
      end else begin
        eat_q  <= eat_q  | (is_apple & is_snake_head);
        self_q <= self_q | (is_snake_head & is_snake_body);
        wall_q <= wall_q | (is_snake_head & in_band);
      end
      case (state_q)
        PLAY: if (frame_end) begin
          if (death) begin
            state_q     <= DEAD;
            game_over_q <= 1'b1;
          end else if (eat_q) begin
            state_q     <= EAT;
            got_apple_q <= 1'b1;
            grow_q      <= 1'b1;
            score_q     <= score_d;
          end
        end
        EAT: if (frame_end) begin
          got_apple_q <= 1'b0;
          state_q     <= death ? DEAD : PLAY;
          game_over_q <= death;
        end
        DEAD: if (restart) begin
          state_q     <= PLAY;
          game_over_q <= 1'b0;
          score_q     <= 16'h0000;
        end
        default: state_q <= PLAY;
      endcase
    end
  end

  assign got_apple = got_apple_q;
  assign grow      = grow_q;
  assign game_over = game_over_q;
  assign score_bcd = score_q;

endmodule

// File: tb/tb_apple_eat_detect.sv
// Directed bench for apple_eat_detect: hand-built frames for eat/death/restart
// sequences plus vector tables for wall boundaries and the saturating BCD adder.
module tb_apple_eat_detect;

  logic        clock = 1'b0;
  logic        reset;
  logic        vert_sync;
  logic [9:0]  pixel_row;
  logic [9:0]  pixel_column;
  logic        is_apple;
  logic        is_snake_head;
  logic        is_snake_body;
  logic        restart;
  logic        got_apple;
  logic        grow;
  logic        game_over;
  logic [15:0] score_bcd;

  logic [15:0] addBcd;
  logic [3:0]  addAddend;
  logic [15:0] addSum;

  int nCompared   = 0;
  int nMismatched = 0;

  typedef struct {
    logic [9:0] row;
    logic [9:0] col;
    logic       expDead;
  } wallVec_t;

  typedef struct {
    logic [15:0] bcd;
    logic [3:0]  addend;
    logic [15:0] expSum;
  } addVec_t;

  wallVec_t wallTab[8];
  addVec_t  addTab[10];

  always #5 clock = ~clock;

  apple_eat_detect dut (
    .clock         (clock),
    .reset         (reset),
    .vert_sync     (vert_sync),
    .pixel_row     (pixel_row),
    .pixel_column  (pixel_column),
    .is_apple      (is_apple),
    .is_snake_head (is_snake_head),
    .is_snake_body (is_snake_body),
    .restart       (restart),
    .got_apple     (got_apple),
    .grow          (grow),
    .game_over     (game_over),
    .score_bcd     (score_bcd)
  );

  bcd_add_sat uAdd (
    .bcd_i    (addBcd),
    .addend_i (addAddend),
    .sum_o    (addSum)
  );

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // One clock with the given pixel flags, then the pixel goes back to background.
  task automatic applyStimulus(input int row, input int col, input logic apple,
                               input logic head, input logic body);
    pixel_row     = 10'(row);
    pixel_column  = 10'(col);
    is_apple      = apple;
    is_snake_head = head;
    is_snake_body = body;
    tick(1);
    is_apple      = 1'b0;
    is_snake_head = 1'b0;
    is_snake_body = 1'b0;
  endtask

  // Outputs reflect the frame-end decision when this returns.
  task automatic frameEnd();
    vert_sync = 1'b0;
    tick(1);
    vert_sync = 1'b1;
  endtask

  task automatic restartGame();
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
  endtask

  task automatic eatOnce();
    applyStimulus(300, 400, 1'b1, 1'b1, 1'b0);
    frameEnd();
    tick(2);
    frameEnd();
    tick(2);
  endtask

  initial begin
    wallTab[0] = '{10'd200, 10'd9,   1'b1};
    wallTab[1] = '{10'd200, 10'd10,  1'b0};
    wallTab[2] = '{10'd200, 10'd629, 1'b0};
    wallTab[3] = '{10'd200, 10'd630, 1'b1};
    wallTab[4] = '{10'd9,   10'd300, 1'b1};
    wallTab[5] = '{10'd10,  10'd300, 1'b0};
    wallTab[6] = '{10'd469, 10'd300, 1'b0};
    wallTab[7] = '{10'd470, 10'd300, 1'b1};

    addTab[0] = '{16'h0000, 4'd1, 16'h0001};
    addTab[1] = '{16'h0019, 4'd1, 16'h0020};
    addTab[2] = '{16'h9998, 4'd3, 16'h9999};
    addTab[3] = '{16'h9999, 4'd1, 16'h9999};
    addTab[4] = '{16'h0099, 4'd1, 16'h0100};
    addTab[5] = '{16'h0999, 4'd9, 16'h1008};
    addTab[6] = '{16'h9991, 4'd9, 16'h9999};
    addTab[7] = '{16'h1234, 4'd5, 16'h1239};
    addTab[8] = '{16'h0009, 4'd9, 16'h0018};
    addTab[9] = '{16'h9989, 4'd9, 16'h9998};

    addBcd = 16'h0000;
    addAddend = 4'd0;
    restart = 1'b0;
    vert_sync = 1'b1;

    // Reset held with the head sitting on the apple.
    reset = 1'b1;
    pixel_row = 10'd200;
    pixel_column = 10'd200;
    is_apple = 1'b1;
    is_snake_head = 1'b1;
    is_snake_body = 1'b0;
    tick(3);
    checkOutput("reset got_apple", {15'd0, got_apple}, 16'd0);
    checkOutput("reset grow", {15'd0, grow}, 16'd0);
    checkOutput("reset game_over", {15'd0, game_over}, 16'd0);
    checkOutput("reset score", score_bcd, 16'h0000);
    reset = 1'b0;
    is_apple = 1'b0;
    is_snake_head = 1'b0;
    tick(2);
    frameEnd();
    checkOutput("post-reset no eat", {15'd0, got_apple}, 16'd0);
    checkOutput("post-reset score", score_bcd, 16'h0000);
    tick(2);

    // Eight-pixel overlap at (400,300), plus harmless apple-only and body-only pixels.
    applyStimulus(100, 100, 1'b1, 1'b0, 1'b0);
    applyStimulus(101, 100, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) applyStimulus(300, 400 + i, 1'b1, 1'b1, 1'b0);
    frameEnd();
    checkOutput("eat got_apple", {15'd0, got_apple}, 16'd1);
    checkOutput("eat grow", {15'd0, grow}, 16'd1);
    checkOutput("eat score", score_bcd, 16'h0001);
    checkOutput("eat game_over", {15'd0, game_over}, 16'd0);
    tick(1);
    checkOutput("grow one clock", {15'd0, grow}, 16'd0);
    checkOutput("got_apple held", {15'd0, got_apple}, 16'd1);
    tick(5);
    checkOutput("got_apple held late", {15'd0, got_apple}, 16'd1);

    // Second eat during EAT is ignored.
    applyStimulus(300, 400, 1'b1, 1'b1, 1'b0);
    frameEnd();
    checkOutput("EAT end got_apple", {15'd0, got_apple}, 16'd0);
    checkOutput("EAT end grow", {15'd0, grow}, 16'd0);
    checkOutput("EAT no double count", score_bcd, 16'h0001);
    tick(2);
    applyStimulus(300, 400, 1'b1, 1'b1, 1'b0);
    frameEnd();
    checkOutput("back in PLAY eats", score_bcd, 16'h0002);
    checkOutput("back in PLAY got_apple", {15'd0, got_apple}, 16'd1);
    tick(2);
    frameEnd();
    tick(2);

    // Eat and self hit in the same frame: death wins.
    applyStimulus(300, 400, 1'b1, 1'b1, 1'b0);
    applyStimulus(301, 400, 1'b0, 1'b1, 1'b1);
    frameEnd();
    checkOutput("self game_over", {15'd0, game_over}, 16'd1);
    checkOutput("self got_apple", {15'd0, got_apple}, 16'd0);
    checkOutput("self grow", {15'd0, grow}, 16'd0);
    checkOutput("self score kept", score_bcd, 16'h0002);
    tick(2);
    applyStimulus(300, 400, 1'b1, 1'b1, 1'b0);
    frameEnd();
    checkOutput("DEAD ignores eat", {15'd0, got_apple}, 16'd0);
    checkOutput("DEAD score frozen", score_bcd, 16'h0002);
    tick(3);
    checkOutput("DEAD holds", {15'd0, game_over}, 16'd1);
    restartGame();
    checkOutput("restart game_over", {15'd0, game_over}, 16'd0);
    checkOutput("restart score", score_bcd, 16'h0000);
    tick(2);

    // Wall band boundaries.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(int'(wallTab[i].row), int'(wallTab[i].col), 1'b0, 1'b1, 1'b0);
      frameEnd();
      checkOutput($sformatf("wall r%0d c%0d", wallTab[i].row, wallTab[i].col),
                  {15'd0, game_over}, {15'd0, wallTab[i].expDead});
      if (wallTab[i].expDead) restartGame();
      tick(2);
    end

    // Wall hit during EAT: die and drop got_apple.
    applyStimulus(300, 400, 1'b1, 1'b1, 1'b0);
    frameEnd();
    checkOutput("pre-wall eat score", score_bcd, 16'h0001);
    tick(2);
    applyStimulus(200, 5, 1'b0, 1'b1, 1'b0);
    frameEnd();
    checkOutput("EAT wall game_over", {15'd0, game_over}, 16'd1);
    checkOutput("EAT wall got_apple", {15'd0, got_apple}, 16'd0);
    restartGame();
    checkOutput("restart after wall", score_bcd, 16'h0000);
    tick(2);

    // Score carry 0019 -> 0020.
    for (int i = 0; i < 19; i++) eatOnce();
    checkOutput("score 19", score_bcd, 16'h0019);
    eatOnce();
    checkOutput("score carry 20", score_bcd, 16'h0020);

    // Reset in the middle of EAT.
    applyStimulus(300, 400, 1'b1, 1'b1, 1'b0);
    frameEnd();
    checkOutput("pre-reset eat", {15'd0, got_apple}, 16'd1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    checkOutput("mid-EAT reset got_apple", {15'd0, got_apple}, 16'd0);
    checkOutput("mid-EAT reset score", score_bcd, 16'h0000);
    tick(2);
    frameEnd();
    checkOutput("no pending eat", {15'd0, got_apple}, 16'd0);
    checkOutput("no pending score", score_bcd, 16'h0000);
    tick(2);

    // Saturating BCD adder vectors.
    for (int i = 0; i < 10; i++) begin
      addBcd = addTab[i].bcd;
      addAddend = addTab[i].addend;
      #1;
      checkOutput($sformatf("bcd %h+%0d", addTab[i].bcd, addTab[i].addend),
                  addSum, addTab[i].expSum);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
